// File: rtl/dot_product_seq.sv
// dot_product_seq: drives the shared ALU to compute one dot product sum(a[i]*b[i]) for
// i = 0..len-1. Operand pairs are fetched over an op_req/op_valid handshake. The ALU only
// evaluates when its opcode changes, so each non-zero opcode is held for one cycle and then
// followed by a one-cycle spacer (alu_op = 0). The result is captured at the end of that spacer.
//
// Ports
//   clk_i       clock, rising edge
//   rst_n       asynchronous active-low reset
//   start_i     one-cycle start request, sampled only in idle
//   len_i       element count, latched on an accepted start
//   busy_o      high from the cycle after start until done completes
//   done_o      one-cycle pulse; result_o is valid then and holds afterwards
//   result_o    final accumulator value
//   op_req_o    operand-pair request, held until op_valid_i
//   op_valid_i  operand pair present on op_a_i / op_b_i
//   op_a_i      row-vector element
//   op_b_i      column-vector element
//   alu_in1_o   ALU operand 1 (accumulator side)
//   alu_in2_o   ALU operand 2
//   alu_op_o    1=add 2=sub 3=mul 4=dec 5=clear 0=spacer
//   alu_out_i   ALU result
//   alu_z_i     ALU zero flag (valid after dec/clear)
module dot_product_seq #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o,
  output logic              op_req_o,
  input  logic              op_valid_i,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  output logic [DATA_W-1:0] alu_in1_o,
  output logic [DATA_W-1:0] alu_in2_o,
  output logic [2:0]        alu_op_o,
  input  logic [DATA_W-1:0] alu_out_i,
  input  logic              alu_z_i
);

  localparam logic [2:0] OpNone  = 3'd0;
  localparam logic [2:0] OpAdd   = 3'd1;
  localparam logic [2:0] OpMul   = 3'd3;
  localparam logic [2:0] OpDec   = 3'd4;
  localparam logic [2:0] OpClear = 3'd5;

  typedef enum logic [3:0] {
    StIdle, StZero, StZeroC, StFetch, StMul, StMulC, StAdd, StAddC, StDec, StDecC, StDone
  } state_e;

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              op_req_q, op_req_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_in1_q, alu_in1_d;
  logic [DATA_W-1:0] alu_in2_q, alu_in2_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] count_q, count_d;

  // Outputs are registered: each branch sets the output values that belong to the state it
  // enters. The product captured in MUL_C goes straight into alu_in2, which doubles as the
  // product register.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    op_req_d  = 1'b0;
    alu_op_d  = OpNone;
    alu_in1_d = alu_in1_q;
    alu_in2_d = alu_in2_q;
    result_d  = result_q;
    acc_d     = acc_q;
    count_d   = count_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          count_d  = DATA_W'(len_i);
          busy_d   = 1'b1;
          alu_op_d = OpClear;
          state_d  = StZero;
        end
      end
      StZero: state_d = StZeroC;
      StZeroC: begin
        acc_d = alu_out_i;
        if (count_q == '0) begin
          result_d = alu_out_i;
          done_d   = 1'b1;
          state_d  = StDone;
        end else begin
          op_req_d = 1'b1;
          state_d  = StFetch;
        end
      end
      StFetch: begin
        if (op_valid_i) begin
          alu_op_d  = OpMul;
          alu_in1_d = op_a_i;
          alu_in2_d = op_b_i;
          state_d   = StMul;
        end else begin
          op_req_d = 1'b1;
        end
      end
      StMul: state_d = StMulC;
      StMulC: begin
        alu_op_d  = OpAdd;
        alu_in1_d = acc_q;
        alu_in2_d = alu_out_i;
        state_d   = StAdd;
      end
      StAdd: state_d = StAddC;
      StAddC: begin
        acc_d     = alu_out_i;
        alu_op_d  = OpDec;
        alu_in1_d = count_q;
        alu_in2_d = '0;
        state_d   = StDec;
      end
      StDec: state_d = StDecC;
      StDecC: begin
        count_d = alu_out_i;
        if (alu_z_i) begin
          result_d = acc_q;
          done_d   = 1'b1;
          state_d  = StDone;
        end else begin
          op_req_d = 1'b1;
          state_d  = StFetch;
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      op_req_q  <= 1'b0;
      alu_op_q  <= OpNone;
      alu_in1_q <= '0;
      alu_in2_q <= '0;
      result_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      op_req_q  <= op_req_d;
      alu_op_q  <= alu_op_d;
      alu_in1_q <= alu_in1_d;
      alu_in2_q <= alu_in2_d;
      result_q  <= result_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign result_o  = result_q;
  assign op_req_o  = op_req_q;
  assign alu_op_o  = alu_op_q;
  assign alu_in1_o = alu_in1_q;
  assign alu_in2_o = alu_in2_q;

endmodule
